// File: rtl/mips_pkg.sv
// Shared pipeline types for the hazard controller: operand-forwarding selects,
// the shadow-pipeline entry layout, and the register-match helper.
package mips_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
      logic [4:0] rs;
      logic [4:0] rt;
   } shadow_entry_t;

   localparam shadow_entry_t SHADOW_BUBBLE = shadow_entry_t'(18'd0);

   // $0 is hard-wired, so an entry targeting it never produces a dependency.
   function automatic logic entry_match(input shadow_entry_t e, input logic [4:0] r);
      return e.valid & e.reg_write & (e.rd != 5'd0) & (e.rd == r);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and hazard/forwarding response bundle of hazard_ctrl.
interface hazard_ctrl_if;
   import mips_pkg::*;

   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_is_load;
   logic        branch_taken;

   logic        stall;
   logic        flush;
   fwd_sel_t    fwd_a;
   fwd_sel_t    fwd_b;
   logic        rf_write;
   logic [4:0]  rf_addr;
   logic [15:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_rd, id_reg_write, id_is_load, branch_taken,
      input  stall, flush, fwd_a, fwd_b, rf_write, rf_addr, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_rd, id_reg_write, id_is_load, branch_taken,
      output stall, flush, fwd_a, fwd_b, rf_write, rf_addr, stall_count
   );

endinterface

// File: rtl/hazard_ctrl_match.sv
// Per-operand dependency check: forwarding select for the EX operand and the
// stall request for the decode source. Behaviour depends on HAZARD_FORWARDING_EN.
module hazard_match
   import mips_pkg::*;
(
`ifdef HAZARD_FORWARDING_EN
   input  logic [4:0]    ex_src,
`endif
   input  logic [4:0]    id_src,
   input  logic          id_uses,
   input  shadow_entry_t ex_e,
   input  shadow_entry_t mem_e,
   input  shadow_entry_t wb_e,
   output fwd_sel_t      fwd,
   output logic          hazard
);

`ifdef HAZARD_FORWARDING_EN
   logic unused_s;
   assign unused_s = ^{ex_e.rs, ex_e.rt, mem_e.is_load, mem_e.rs, mem_e.rt,
                       wb_e.is_load, wb_e.rs, wb_e.rt};

   // MEM holds the younger result, so it takes priority over WB.
   always_comb begin
      fwd = FWD_RF;
      if (!ex_e.valid) begin
         fwd = FWD_RF;
      end else if (entry_match(mem_e, ex_src)) begin
         fwd = FWD_MEM;
      end else if (entry_match(wb_e, ex_src)) begin
         fwd = FWD_WB;
      end else begin
         fwd = FWD_RF;
      end
   end

   // Only a load in EX cannot be forwarded in time.
   always_comb begin
      hazard = 1'b0;
      if (id_uses) begin
         hazard = ex_e.is_load & entry_match(ex_e, id_src);
      end else begin
         hazard = 1'b0;
      end
   end
`else
   logic unused_s;
   assign unused_s = ^{ex_e.is_load, ex_e.rs, ex_e.rt, mem_e.is_load, mem_e.rs,
                       mem_e.rt, wb_e.is_load, wb_e.rs, wb_e.rt};

   assign fwd = FWD_RF;

   // Without bypass or regfile write-through, any in-flight producer stalls.
   always_comb begin
      hazard = 1'b0;
      if (id_uses) begin
         hazard = entry_match(ex_e, id_src) | entry_match(mem_e, id_src) |
                  entry_match(wb_e, id_src);
      end else begin
         hazard = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS-style hazard controller: EX/MEM/WB shadow pipeline, load-use stall,
// branch flush, operand forwarding (enabled by HAZARD_FORWARDING_EN), stall counter.
module hazard_ctrl
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave bus
);

   shadow_entry_t ex_r;
   shadow_entry_t mem_r;
   shadow_entry_t wb_r;
   shadow_entry_t id_entry_s;
   logic [15:0]   stall_count_r;
   logic          haz_a_s;
   logic          haz_b_s;
   logic          stall_s;
   logic          flush_s;
   fwd_sel_t      fwd_a_s;
   fwd_sel_t      fwd_b_s;

   hazard_match u_match_a (
`ifdef HAZARD_FORWARDING_EN
      .ex_src  (ex_r.rs),
`endif
      .id_src  (bus.id_rs),
      .id_uses (bus.id_uses_rs),
      .ex_e    (ex_r),
      .mem_e   (mem_r),
      .wb_e    (wb_r),
      .fwd     (fwd_a_s),
      .hazard  (haz_a_s)
   );

   hazard_match u_match_b (
`ifdef HAZARD_FORWARDING_EN
      .ex_src  (ex_r.rt),
`endif
      .id_src  (bus.id_rt),
      .id_uses (bus.id_uses_rt),
      .ex_e    (ex_r),
      .mem_e   (mem_r),
      .wb_e    (wb_r),
      .fwd     (fwd_b_s),
      .hazard  (haz_b_s)
   );

   // Pack the decode instruction into a shadow entry.
   always_comb begin
      id_entry_s           = SHADOW_BUBBLE;
      id_entry_s.valid     = 1'b1;
      id_entry_s.rd        = bus.id_rd;
      id_entry_s.reg_write = bus.id_reg_write;
      id_entry_s.is_load   = bus.id_is_load;
      id_entry_s.rs        = bus.id_rs;
      id_entry_s.rt        = bus.id_rt;
   end

   // A taken branch squashes decode, so it overrides any stall.
   always_comb begin
      flush_s = bus.branch_taken;
      stall_s = 1'b0;
      if (bus.id_valid && !flush_s) begin
         stall_s = haz_a_s | haz_b_s;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Shadow pipeline: MEM/WB always advance, EX takes decode or a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r  <= SHADOW_BUBBLE;
         mem_r <= SHADOW_BUBBLE;
         wb_r  <= SHADOW_BUBBLE;
      end else begin
         mem_r <= ex_r;
         wb_r  <= mem_r;
         if (bus.id_valid && !stall_s && !flush_s) begin
            ex_r <= id_entry_s;
         end else begin
            ex_r <= SHADOW_BUBBLE;
         end
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= 16'd0;
      end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
         stall_count_r <= stall_count_r + 16'd1;
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign bus.stall       = stall_s;
   assign bus.flush       = flush_s;
   assign bus.fwd_a       = fwd_a_s;
   assign bus.fwd_b       = fwd_b_s;
   assign bus.rf_write    = wb_r.valid & wb_r.reg_write & (wb_r.rd != 5'd0);
   assign bus.rf_addr     = wb_r.rd;
   assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow the
// HAZARD_FORWARDING_EN setting of the build.
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_cnt;

   hazard_ctrl_if hif ();

   hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic br);
      hif.id_valid     = v;
      hif.id_rs        = rs;
      hif.id_uses_rs   = urs;
      hif.id_rt        = rt;
      hif.id_uses_rt   = urt;
      hif.id_rd        = rd;
      hif.id_reg_write = rw;
      hif.id_is_load   = ld;
      hif.branch_taken = br;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nop;
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain;
      nop;
      repeat (3) tick;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;
      rst_n   = 1'b0;
      nop;
      hif.branch_taken = 1'b1;
      #1;
      chk("rst_stall", {15'd0, hif.stall}, 16'd0);
      chk("rst_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
      chk("rst_fwd_b", {14'd0, hif.fwd_b}, 16'd0);
      chk("rst_rf_write", {15'd0, hif.rf_write}, 16'd0);
      chk("rst_count", hif.stall_count, 16'd0);
      chk("rst_flush_hi", {15'd0, hif.flush}, 16'd1);
      hif.branch_taken = 1'b0;
      #1;
      chk("rst_flush_lo", {15'd0, hif.flush}, 16'd0);
      tick;
      @(negedge clk);
      rst_n = 1'b1;
      tick;

`ifdef HAZARD_FORWARDING_EN
      // add $3 then sub reading $3: MEM forward, then WB forward a cycle later
      drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      chk("add3_stall", {15'd0, hif.stall}, 16'd0);
      tick;
      drv(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      chk("sub_stall", {15'd0, hif.stall}, 16'd0);
      chk("sub_pre_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
      tick;
      drv(1'b1, 5'd8, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("fwd_a_mem", {14'd0, hif.fwd_a}, 16'd1);
      chk("fwd_b_rf", {14'd0, hif.fwd_b}, 16'd0);
      tick;
      nop;
      chk("fwd_b_wb", {14'd0, hif.fwd_b}, 16'd2);
      chk("fwd_a_none", {14'd0, hif.fwd_a}, 16'd0);
      chk("wb_rf_write", {15'd0, hif.rf_write}, 16'd1);
      chk("wb_rf_addr", {11'd0, hif.rf_addr}, 16'd3);
      drain;

      // both MEM and WB write $9: MEM wins
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      tick;
      tick;
      drv(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("prio_stall", {15'd0, hif.stall}, 16'd0);
      tick;
      nop;
      chk("prio_fwd_a", {14'd0, hif.fwd_a}, 16'd1);
      chk("prio_fwd_b", {14'd0, hif.fwd_b}, 16'd1);
      drain;

      // lw $5 then rt reader: one stall, bubble, then WB forward
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick;
      drv(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("lu_stall", {15'd0, hif.stall}, 16'd1);
      tick;
      exp_cnt = 1;
      chk("lu_one_cycle", {15'd0, hif.stall}, 16'd0);
      chk("lu_bubble_fwd", {14'd0, hif.fwd_b}, 16'd0);
      chk("lu_count", hif.stall_count, exp_cnt[15:0]);
      tick;
      nop;
      chk("lu_fwd_b", {14'd0, hif.fwd_b}, 16'd2);
      drain;
`else
      // add $7 then reader of $7: stalls through EX, MEM and WB
      drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      chk("add7_stall", {15'd0, hif.stall}, 16'd0);
      tick;
      drv(1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("raw_ex", {15'd0, hif.stall}, 16'd1);
      tick;
      chk("raw_mem", {15'd0, hif.stall}, 16'd1);
      tick;
      chk("raw_wb", {15'd0, hif.stall}, 16'd1);
      chk("raw_rf_write", {15'd0, hif.rf_write}, 16'd1);
      chk("raw_rf_addr", {11'd0, hif.rf_addr}, 16'd7);
      tick;
      exp_cnt = 3;
      chk("raw_release", {15'd0, hif.stall}, 16'd0);
      chk("raw_count", hif.stall_count, exp_cnt[15:0]);
      tick;
      nop;
      chk("raw_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
      chk("raw_fwd_b", {14'd0, hif.fwd_b}, 16'd0);
      drain;
`endif

      // loads/writes to $0 in every stage never create a dependency
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      repeat (3) tick;
      drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("zero_stall", {15'd0, hif.stall}, 16'd0);
      chk("zero_rf_write", {15'd0, hif.rf_write}, 16'd0);
      tick;
      nop;
      chk("zero_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
      chk("zero_fwd_b", {14'd0, hif.fwd_b}, 16'd0);
      chk("zero_rf_write2", {15'd0, hif.rf_write}, 16'd0);
      drain;

      // taken branch coincident with load-use: flush wins, EX gets a bubble
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick;
      drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1);
      chk("br_flush", {15'd0, hif.flush}, 16'd1);
      chk("br_stall", {15'd0, hif.stall}, 16'd0);
      tick;
      nop;
      chk("br_flush_lo", {15'd0, hif.flush}, 16'd0);
      chk("br_count", hif.stall_count, exp_cnt[15:0]);
      tick;
      chk("br_lw_write", {15'd0, hif.rf_write}, 16'd1);
      chk("br_lw_addr", {11'd0, hif.rf_addr}, 16'd5);
      tick;
      chk("br_bubble", {15'd0, hif.rf_write}, 16'd0);
      drain;

      // reset asserted with three writes in flight
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      tick;
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
      tick;
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
      tick;
      nop;
      chk("pre_rst_write", {15'd0, hif.rf_write}, 16'd1);
      chk("pre_rst_addr", {11'd0, hif.rf_addr}, 16'd10);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_write", {15'd0, hif.rf_write}, 16'd0);
      chk("mid_rst_count", hif.stall_count, 16'd0);
      tick;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("post_rst_write%0d", i), {15'd0, hif.rf_write}, 16'd0);
      end
      chk("post_rst_count", hif.stall_count, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1 bit: a real instruction is in decode.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 bits each: decode source register addresses.
REQ-005 SHALL have ports id_uses_rs and id_uses_rt, input, 1 bit each: the decode instruction reads rs / rt.
REQ-006 SHALL have port id_rd, input, 5 bits: decode destination register address.
REQ-007 SHALL have port id_reg_write, input, 1 bit: the decode instruction writes id_rd.
REQ-008 SHALL have port id_is_load, input, 1 bit: the decode instruction is a load.
REQ-009 SHALL have port branch_taken, input, 1 bit: a branch resolved taken in EX.
REQ-010 SHALL have port stall, output, 1 bit: hold PC and IF/ID; insert a bubble into EX.
REQ-011 SHALL have port flush, output, 1 bit: squash the IF/ID instruction.
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2 bits each: EX operand select; 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
REQ-013 SHALL have ports rf_write (1 bit) and rf_addr (5 bits), output: register-file write enable and address from the WB shadow entry.
REQ-014 SHALL have port stall_count, output, 16 bits: number of stall cycles since reset.

Function
REQ-015 SHALL keep shadow entries EX, MEM and WB, each holding {valid, rd, reg_write, is_load, rs, rt}.
REQ-016 SHALL advance the shadow pipeline every clock: MEM <= EX and WB <= MEM, unconditionally.
REQ-017 SHALL load EX from the decode inputs only when id_valid=1, stall=0 and flush=0; otherwise EX SHALL load a bubble (valid=0).
REQ-018 SHALL treat rd=0 as a non-write: an entry with rd=0 never matches any source.
REQ-019 SHALL define "match(S, r)" as S.valid & S.reg_write & S.rd!=0 & S.rd==r.
REQ-020 SHALL drive flush=branch_taken combinationally; flush SHALL force stall=0 in the same cycle.
REQ-021 SHALL compute fwd_a from the EX entry's rs: 01 if match(MEM, rs), else 10 if match(WB, rs), else 00; the MEM stage wins when both match. fwd_b SHALL follow the same rule using rt.
REQ-022 SHALL compute fwd_a/fwd_b as 00 whenever the EX entry is invalid.
REQ-023 SHALL assert stall (load-use) when id_valid=1, EX.is_load=1, and match(EX, id_rs)&id_uses_rs or match(EX, id_rt)&id_uses_rt; this gives exactly 1 stall cycle per load-use pair.
REQ-024 SHALL drive rf_write=WB.valid&WB.reg_write&(WB.rd!=0) and rf_addr=WB.rd.
REQ-025 SHALL increment stall_count on every cycle with stall=1, saturating at 16'hFFFF.
REQ-026 SHALL keep stall and flush combinational (zero latency), with state changing only at posedge clk.

Reset
REQ-027 SHALL, while rst_n=0, clear all shadow entries to valid=0 and clear stall_count to 0.
REQ-028 SHALL therefore hold stall=0, fwd_a=fwd_b=00 and rf_write=0 during reset; flush SHALL still follow branch_taken.
REQ-029 SHALL discard all in-flight entries when reset is asserted mid-operation, with no writes issued after release.

Configuration
REQ-030 SHALL, when macro HAZARD_FORWARDING_EN is defined, implement REQ-021 and REQ-023 as written.
REQ-031 SHALL, when HAZARD_FORWARDING_EN is undefined, tie fwd_a/fwd_b to 00 and assert stall when any decode source with its uses bit set matches EX, MEM or WB. The regfile has no write-through, so the WB match also stalls.

Structure
REQ-032 SHALL place the fwd_sel_t constants (FWD_RF, FWD_MEM, FWD_WB) and the shadow-entry struct in shared package mips_pkg.
REQ-033 SHALL implement the match/priority logic once, as sub-module hazard_match, instantiated once per operand.

Verification
REQ-034 SHALL verify: add $3 in EX->MEM, then sub reading $3 in EX -> fwd_a=01 in that cycle; one cycle later a reader of $3 gets fwd=10.
REQ-035 SHALL verify: lw $5 in EX, decode reads $5 via rt -> stall=1 for exactly 1 cycle, EX gets a bubble, then fwd_b=10, stall_count=1.
REQ-036 SHALL verify: writes to $0 from any stage -> stall=0, fwd=00, rf_write=0.
REQ-037 SHALL verify: branch_taken=1 together with a load-use condition -> flush=1, stall=0, EX bubble, stall_count unchanged.
REQ-038 SHALL verify: with HAZARD_FORWARDING_EN undefined, add $7 then a dependent reader of $7 -> stall=1 for 3 cycles, then the reader proceeds with fwd=00.
REQ-039 SHALL verify: rst_n pulsed low while 3 writes are in flight -> rf_write stays 0 after release and stall_count=0.
